axil_cfg_sequencer: RTL and testbench

//   Synthesizable AXI-Lite master that walks a command table and configures downstream register banks.
//   On start it executes WRITE, READ and POLL commands in order over one AXI-Lite master port.

---
 rtl/axil_if.sv | 34 +++
 rtl/axil_cfg_sequencer.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_axil_cfg_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_if.sv
// AXI-Lite bus bundle shared by the configuration sequencer (master side)
// and the register interconnect / slaves (slave side).
interface axil_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_cfg_sequencer.sv
// AXI-Lite configuration sequencer: walks a command table held in an
// external synchronous ROM (cmd_idx_o -> cmd_i one cycle later) and issues
// WRITE / READ / POLL transactions one at a time on m_axil.
// Optional feature: define AXIL_SEQ_TIMEOUT_EN to bound each POLL to
// POLL_LIMIT read attempts; otherwise a POLL retries until it matches.
module axil_cfg_sequencer #(
    parameter int  DATA_WIDTH = 32,
    parameter int  ADDR_WIDTH = 32,
    parameter int  NUM_CMDS   = 16,
    parameter int  POLL_LIMIT = 1024,
    localparam int IDX_W      = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1,
    localparam int CMD_W      = 2 + ADDR_WIDTH + 2 * DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [IDX_W-1:0]      err_idx_o,
    output logic [IDX_W-1:0]      cmd_idx_o,
    input  logic [CMD_W-1:0]      cmd_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    axil_if.master                m_axil
);
    localparam logic [1:0] OP_END   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CMDS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_WR_AW_W, S_WR_B,
        S_RD_AR, S_RD_R, S_CHECK, S_NEXT, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    error_q, error_d;
    logic [IDX_W-1:0]        err_idx_q, err_idx_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [1:0]              op_q, op_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   mask_q, mask_d;

    logic [1:0]            cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic [DATA_WIDTH-1:0] cmd_mask;

    assign cmd_op   = cmd_i[CMD_W-1 -: 2];
    assign cmd_addr = cmd_i[2*DATA_WIDTH +: ADDR_WIDTH];
    assign cmd_data = cmd_i[DATA_WIDTH +: DATA_WIDTH];
    assign cmd_mask = cmd_i[0 +: DATA_WIDTH];

`ifdef AXIL_SEQ_TIMEOUT_EN
    localparam int PCNT_W = $clog2(POLL_LIMIT + 1);
    logic [PCNT_W-1:0] poll_cnt_q, poll_cnt_d;
`else
    logic unused_poll_limit;
    assign unused_poll_limit = (POLL_LIMIT == 0);
`endif

    // Next-state and next-output logic for the command walker.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        error_d   = error_q;
        err_idx_d = err_idx_q;
        rdata_d   = rdata_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        araddr_d  = araddr_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        op_d      = op_q;
        data_d    = data_q;
        mask_d    = mask_q;
`ifdef AXIL_SEQ_TIMEOUT_EN
        poll_cnt_d = poll_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    idx_d   = '0;
                    error_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                op_d   = cmd_op;
                data_d = cmd_data;
                mask_d = cmd_mask;
                if (cmd_op == OP_WRITE) begin
                    awaddr_d  = cmd_addr;
                    wdata_d   = cmd_data;
                    wstrb_d   = '1;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WR_AW_W;
                end else if (cmd_op == OP_END) begin
                    state_d = S_DONE;
                end else begin
                    araddr_d  = cmd_addr;
                    arvalid_d = 1'b1;
                    state_d   = S_RD_AR;
`ifdef AXIL_SEQ_TIMEOUT_EN
                    poll_cnt_d = '0;
`endif
                end
            end
            S_WR_AW_W: begin
                // AW and W retire independently; the state only advances
                // once both completion flags have been registered.
                if (awvalid_q && m_axil.awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && m_axil.wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_q && w_done_q) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_B;
                end
            end
            S_WR_B: begin
                if (m_axil.bvalid) begin
                    bready_d = 1'b0;
                    if (m_axil.bresp != 2'b00) begin
                        error_d   = 1'b1;
                        err_idx_d = idx_q;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_RD_AR: begin
                if (m_axil.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_R;
                end
            end
            S_RD_R: begin
                if (m_axil.rvalid) begin
                    rready_d = 1'b0;
                    rdata_d  = m_axil.rdata;
                    if (m_axil.rresp != 2'b00) begin
                        error_d   = 1'b1;
                        err_idx_d = idx_q;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (op_q == OP_READ || ((rdata_q ^ data_q) & mask_q) == '0) begin
                    state_d = S_NEXT;
                end else begin
`ifdef AXIL_SEQ_TIMEOUT_EN
                    if (int'(poll_cnt_q) + 1 >= POLL_LIMIT) begin
                        error_d   = 1'b1;
                        err_idx_d = idx_q;
                        state_d   = S_DONE;
                    end else begin
                        poll_cnt_d = poll_cnt_q + PCNT_W'(1);
                        arvalid_d  = 1'b1;
                        state_d    = S_RD_AR;
                    end
`else
                    arvalid_d = 1'b1;
                    state_d   = S_RD_AR;
`endif
                end
            end
            S_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control and bus-facing registers; all cleared by reset so the bus
    // sees idle valids/readies and zeroed payload immediately.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
            rdata_q   <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            araddr_q  <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef AXIL_SEQ_TIMEOUT_EN
            poll_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
            rdata_q   <= rdata_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            araddr_q  <= araddr_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
`ifdef AXIL_SEQ_TIMEOUT_EN
            poll_cnt_q <= poll_cnt_d;
`endif
        end
    end

    // Latched command payload; only consumed after DECODE has loaded it.
    always_ff @(posedge clk_i) begin
        op_q   <= op_d;
        data_q <= data_d;
        mask_q <= mask_d;
    end

    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign error_o   = error_q;
    assign err_idx_o = err_idx_q;
    assign cmd_idx_o = idx_q;
    assign rdata_o   = rdata_q;

    assign m_axil.awaddr  = awaddr_q;
    assign m_axil.awvalid = awvalid_q;
    assign m_axil.wdata   = wdata_q;
    assign m_axil.wstrb   = wstrb_q;
    assign m_axil.wvalid  = wvalid_q;
    assign m_axil.bready  = bready_q;
    assign m_axil.araddr  = araddr_q;
    assign m_axil.arvalid = arvalid_q;
    assign m_axil.rready  = rready_q;
endmodule

// File: tb/tb_axil_cfg_sequencer.sv
// Bench for axil_cfg_sequencer: table ROM, configurable AXI-Lite slave,
// transaction-level model of the command table and a per-cycle bus monitor.
module tb_axil_cfg_sequencer;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NC = 16;
    localparam int PL = 8;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        busy_o, done_o, error_o;
    logic [3:0]  err_idx_o, cmd_idx_o;
    logic [97:0] cmd_r = '0;
    logic [31:0] rdata_o;

    axil_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axil ();

    axil_cfg_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CMDS(NC), .POLL_LIMIT(PL)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .error_o(error_o), .err_idx_o(err_idx_o), .cmd_idx_o(cmd_idx_o), .cmd_i(cmd_r),
        .rdata_o(rdata_o), .m_axil(axil.master)
    );

    always #5 clk = ~clk;

    // Command table ROM with one cycle read latency.
    logic [97:0] rom [NC];
    always @(posedge clk) cmd_r <= rom[cmd_idx_o];

    // Slave configuration and logs.
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [1:0]  cfg_bresp = 2'b00;
    logic [31:0] rd_vals[$];
    logic [31:0] wa_log[$], wd_log[$], ar_log[$];
    logic [3:0]  ws_log[$];
    logic        aw_got, w_got;
    int          aw_cnt, w_cnt, ar_cnt, rd_ptr;

    function automatic logic [31:0] rdval(input int p);
        return (p < rd_vals.size()) ? rd_vals[p] : 32'h0;
    endfunction

    assign axil.awready = axil.awvalid && (aw_cnt >= aw_delay);
    assign axil.wready  = axil.wvalid && (w_cnt >= w_delay);
    assign axil.arready = axil.arvalid && (ar_cnt >= ar_delay);

    always @(posedge clk) begin
        if (rst_i) begin
            aw_got <= 1'b0; w_got <= 1'b0;
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; rd_ptr <= 0;
            axil.bvalid <= 1'b0; axil.bresp <= 2'b00;
            axil.rvalid <= 1'b0; axil.rresp <= 2'b00; axil.rdata <= '0;
        end else begin
            if (axil.awvalid && axil.awready) begin
                aw_got <= 1'b1; aw_cnt <= 0; wa_log.push_back(axil.awaddr);
            end else if (axil.awvalid) aw_cnt <= aw_cnt + 1;
            if (axil.wvalid && axil.wready) begin
                w_got <= 1'b1; w_cnt <= 0;
                wd_log.push_back(axil.wdata); ws_log.push_back(axil.wstrb);
            end else if (axil.wvalid) w_cnt <= w_cnt + 1;
            if (aw_got && w_got) begin
                axil.bvalid <= 1'b1; axil.bresp <= cfg_bresp;
                aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (axil.bvalid && axil.bready) axil.bvalid <= 1'b0;
            if (axil.arvalid && axil.arready) begin
                ar_log.push_back(axil.araddr);
                axil.rvalid <= 1'b1; axil.rdata <= rdval(rd_ptr); axil.rresp <= 2'b00;
                rd_ptr <= rd_ptr + 1; ar_cnt <= 0;
            end else if (axil.arvalid) ar_cnt <= ar_cnt + 1;
            if (axil.rvalid && axil.rready) axil.rvalid <= 1'b0;
        end
    end

    int n_vec = 0, n_fail = 0;
    int done_cnt = 0;
    int aw_rise[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Per-cycle protocol monitor, sampled 1 time unit after each rising edge.
    task automatic monitor();
        logic p_aw = 0, p_awr = 0, p_w = 0, p_wr = 0, p_ar = 0, p_arr = 0, p_done = 0;
        logic busy_exp = 0;
        logic [31:0] p_awaddr = 0, p_araddr = 0;
        int cyc = 0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (rst_i) begin
                check("rst_awvalid", axil.awvalid, 0);
                check("rst_wvalid", axil.wvalid, 0);
                check("rst_arvalid", axil.arvalid, 0);
                check("rst_readies", {axil.bready, axil.rready}, 0);
                check("rst_busy", busy_o, 0);
                busy_exp = 0;
            end else begin
                if (p_aw) check("awvalid_rule", axil.awvalid, !p_awr);
                if (p_w)  check("wvalid_rule", axil.wvalid, !p_wr);
                if (p_ar) check("arvalid_rule", axil.arvalid, !p_arr);
                if (p_aw && !p_awr) check("awaddr_stable", axil.awaddr, p_awaddr);
                if (p_ar && !p_arr) check("araddr_stable", axil.araddr, p_araddr);
                if (p_done) busy_exp = 0;
                else if (!busy_exp && start_i) busy_exp = 1;
                check("busy", busy_o, busy_exp);
                if (p_done) check("done_one_cycle", done_o, 0);
                if (axil.awvalid || axil.wvalid || axil.arvalid)
                    check("one_outstanding", axil.arvalid && (axil.awvalid || axil.wvalid), 0);
                if (done_o) done_cnt++;
                if (axil.awvalid && !p_aw) aw_rise.push_back(cyc);
            end
            p_aw = axil.awvalid; p_awr = axil.awready; p_w = axil.wvalid; p_wr = axil.wready;
            p_ar = axil.arvalid; p_arr = axil.arready; p_done = done_o;
            p_awaddr = axil.awaddr; p_araddr = axil.araddr;
        end
    endtask

    // Transaction-level model of one table run.
    logic [31:0] exp_wa[$], exp_wd[$];
    int          exp_reads;
    logic        exp_err;
    logic [31:0] model_rdata = 0;
    logic [3:0]  model_err_idx = 0;
    int          model_rd_ptr = 0;

    task automatic model_run();
        logic [97:0] cmd;
        logic [1:0]  op;
        logic [31:0] addr, data, mask, v;
        bit stop, fin;
        int att;
        exp_wa.delete(); exp_wd.delete(); exp_reads = 0; exp_err = 0; stop = 0;
        for (int i = 0; i < NC && !stop; i++) begin
            cmd = rom[i];
            op = cmd[97:96]; addr = cmd[95:64]; data = cmd[63:32]; mask = cmd[31:0];
            if (op == 2'b00) stop = 1;
            else if (op == 2'b01) begin
                exp_wa.push_back(addr); exp_wd.push_back(data);
                if (cfg_bresp != 2'b00) begin exp_err = 1; model_err_idx = 4'(i); stop = 1; end
            end else begin
                fin = 0; att = 0;
                while (!fin) begin
                    v = rdval(model_rd_ptr); model_rd_ptr++; exp_reads++; att++;
                    model_rdata = v;
                    if (op == 2'b11 || ((v ^ data) & mask) == 0) fin = 1;
`ifdef AXIL_SEQ_TIMEOUT_EN
                    else if (att >= PL) begin fin = 1; exp_err = 1; model_err_idx = 4'(i); stop = 1; end
`endif
                end
            end
        end
    endtask

    function automatic logic [97:0] mk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
        return {op, a, d, m};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < NC; i++) rom[i] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_i = 1;
        repeat (3) @(negedge clk);
        rst_i = 0;
        model_rdata = 0; model_err_idx = 0; model_rd_ptr = 0;
    endtask

    int wb, rb;

    // Start one table run, wait for done, compare against the model.
    task automatic run(input string tag, input int budget, input int poke);
        int d0; bit ok;
        d0 = done_cnt; wb = wa_log.size(); rb = ar_log.size(); ok = 0;
        model_run();
        @(negedge clk); start_i = 1;
        @(negedge clk); start_i = 0;
        check({tag, "_err_clr_on_start"}, error_o, 0);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            start_i = (c == poke);
            if (done_cnt != d0) begin ok = 1; break; end
        end
        start_i = 0;
        check({tag, "_done_seen"}, ok, 1);
        @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_busy_after"}, busy_o, 0);
        check({tag, "_wr_count"}, wa_log.size() - wb, exp_wa.size());
        for (int k = 0; k < exp_wa.size() && wb + k < wa_log.size(); k++) begin
            check({tag, "_wr_addr"}, wa_log[wb + k], exp_wa[k]);
            check({tag, "_wr_data"}, wd_log[wb + k], exp_wd[k]);
            check({tag, "_wr_strb"}, ws_log[wb + k], 4'hF);
        end
        check({tag, "_rd_count"}, ar_log.size() - rb, exp_reads);
        check({tag, "_rdata"}, rdata_o, model_rdata);
        check({tag, "_error"}, error_o, exp_err);
        check({tag, "_err_idx"}, err_idx_o, model_err_idx);
    endtask

    initial begin
        int ab;
        bit seen;
        fork monitor(); join_none
        clear_rom();
        rst_i = 1;
        repeat (3) @(negedge clk);
        // Reset state of every output.
        check("reset_axi_valids", {axil.awvalid, axil.wvalid, axil.arvalid, axil.bready, axil.rready}, 0);
        check("reset_axi_payload", {axil.awaddr, axil.wdata}, 0);
        check("reset_axi_araddr_wstrb", {axil.araddr, axil.wstrb}, 0);
        check("reset_status", {busy_o, done_o, error_o, err_idx_o, cmd_idx_o}, 0);
        check("reset_rdata", rdata_o, 0);
        rst_i = 0;

        // Two zero-wait writes.
        clear_rom();
        rom[0] = mk(2'b01, 32'h10, 32'hA5A5_0001, 0);
        rom[1] = mk(2'b01, 32'h14, 32'h0000_00FF, 0);
        ab = aw_rise.size();
        run("t1", 200, -1);
        check("t1_lit_addr0", (wa_log.size() > wb) ? wa_log[wb] : 32'hX, 32'h10);
        check("t1_lit_data0", (wd_log.size() > wb) ? wd_log[wb] : 32'hX, 32'hA5A5_0001);
        check("t1_lit_addr1", (wa_log.size() > wb + 1) ? wa_log[wb + 1] : 32'hX, 32'h14);
        check("t1_lit_data1", (wd_log.size() > wb + 1) ? wd_log[wb + 1] : 32'hX, 32'h0000_00FF);
        check("t1_latency", (aw_rise.size() >= ab + 2) ? aw_rise[ab + 1] - aw_rise[ab] : -1, 6);

        // AW accepted before W, then W before AW.
        clear_rom();
        rom[0] = mk(2'b01, 32'h24, 32'h1234_5678, 0);
        aw_delay = 0; w_delay = 3;
        run("t2a", 200, -1);
        check("t2a_lit_count", wa_log.size() - wb, 1);
        aw_delay = 3; w_delay = 0;
        run("t2b", 200, -1);
        check("t2b_lit_data", (wd_log.size() > wb) ? wd_log[wb] : 32'hX, 32'h1234_5678);
        aw_delay = 0; w_delay = 0;

        // POLL until bit 0 set.
        do_reset();
        clear_rom();
        rd_vals = '{32'h0, 32'h0, 32'h0, 32'h1};
        rom[0] = mk(2'b10, 32'h20, 32'h1, 32'h1);
        run("t3", 300, -1);
        check("t3_lit_reads", ar_log.size() - rb, 4);
        check("t3_lit_rdata", rdata_o, 32'h1);
        check("t3_lit_araddr", (ar_log.size() > rb + 3) ? ar_log[rb + 3] : 32'hX, 32'h20);

        // Write error stops the table; next start clears error.
        clear_rom();
        cfg_bresp = 2'b10;
        rom[0] = mk(2'b01, 32'h30, 32'hDEAD_BEEF, 0);
        rom[1] = mk(2'b01, 32'h34, 32'h0000_0001, 0);
        run("t4", 200, -1);
        check("t4_lit_error", error_o, 1);
        check("t4_lit_err_idx", err_idx_o, 0);
        check("t4_lit_wr_count", wa_log.size() - wb, 1);
        cfg_bresp = 2'b00;
        run("t4b", 200, -1);
        check("t4b_lit_error", error_o, 0);

`ifdef AXIL_SEQ_TIMEOUT_EN
        // POLL that never matches runs out of attempts.
        do_reset();
        clear_rom();
        rd_vals.delete();
        rom[0] = mk(2'b01, 32'h50, 32'h5, 0);
        rom[1] = mk(2'b10, 32'h60, 32'h1, 32'h1);
        run("t5", 500, -1);
        check("t5_lit_reads", ar_log.size() - rb, 8);
        check("t5_lit_err_idx", err_idx_o, 1);
`endif

        // Reset while a write address is pending.
        do_reset();
        clear_rom();
        rom[0] = mk(2'b01, 32'h70, 32'h7, 0);
        aw_delay = 20; w_delay = 20;
        @(negedge clk); start_i = 1;
        @(negedge clk); start_i = 0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = axil.awvalid;
        end
        check("t6_awvalid_reached", seen, 1);
        rst_i = 1;
        @(negedge clk);
        check("t6_valids_dropped", {axil.awvalid, axil.wvalid, axil.arvalid}, 0);
        check("t6_busy_dropped", busy_o, 0);
        rst_i = 0;
        model_rdata = 0; model_err_idx = 0; model_rd_ptr = 0;
        aw_delay = 0; w_delay = 0;
        @(negedge clk);

        // Full table with no END entry, and a start pulse mid-run.
        rd_vals = '{32'hCAFE_0003, 32'hCAFE_0007, 32'hCAFE_000B, 32'hCAFE_000F};
        for (int i = 0; i < NC; i++) begin
            if (i % 4 == 3) rom[i] = mk(2'b11, 32'h100 + 32'(4 * i), 0, 0);
            else rom[i] = mk(2'b01, 32'h100 + 32'(4 * i), 32'(i) * 32'h0101_0101, 0);
        end
        run("t6", 1000, 20);
        check("t6_lit_last_idx", cmd_idx_o, 4'd15);
        check("t6_lit_wr_count", wa_log.size() - wb, 12);
        check("t6_lit_rdata", rdata_o, 32'hCAFE_000F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
